// File: rtl/mux_cl_pkg.sv
// Shared constants, FSM state type and lane bit-offset helper for the
// mux_cl_demux write-side demultiplexer.
package mux_cl_pkg;

    localparam int LANES_C = 8;
    localparam int SEL_W_C = 3;

    typedef enum logic {
        S_DIRECT = 1'b0,
        S_AUTO   = 1'b1
    } demux_state_t;

    // Bit offset of lane n inside the packed out_data vector.
    function automatic int lane_slice(input int n, input int width);
        return n * width;
    endfunction

endpackage

// File: rtl/mux_cl_lane.sv
// One holding lane: a data register plus its occupied flag.
// Flush beats write, and write beats ack so a lane can be refilled while it is drained.
module mux_cl_lane #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             ack,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            data_d  = din;
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/mux_cl_demux.sv
// Registered 1-to-LANES demultiplexer with direct-select and auto-increment
// (serial-to-parallel framing) modes, per-lane hold-until-ack.
module mux_cl_demux
    import mux_cl_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LANES = LANES_C,
    parameter int SEL_W = SEL_W_C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   auto_mode,
    input  logic                   flush,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ack,
    output logic [SEL_W-1:0]       ptr,
    output logic                   frame_done
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready never depends on in_valid; the producer may hold in_valid
    // with stable data until it sees in_ready.

    demux_state_t     state_d, state_q;
    logic [SEL_W-1:0] ptr_d, ptr_q;
    logic             frame_done_d, frame_done_q;
    logic [SEL_W-1:0] tgt;
    logic             mode_ok;
    logic             accept;
    logic [LANES-1:0] wr_en;

    assign tgt     = (state_q == S_AUTO) ? ptr_q : in_sel;
    assign mode_ok = (state_q == S_AUTO) == auto_mode;
    assign in_ready = (~out_valid[tgt] | out_ack[tgt]) & ~flush & mode_ok;
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[tgt] = 1'b1;
        end
    end

    always_comb begin
        state_d      = auto_mode ? S_AUTO : S_DIRECT;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        if (flush || !mode_ok) begin
            ptr_d = '0;
        end else if (accept && state_q == S_AUTO) begin
            ptr_d        = ptr_q + 1'b1;
            frame_done_d = (ptr_q == SEL_W'(LANES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DIRECT;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        mux_cl_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_en (wr_en[n]),
            .ack   (out_ack[n]),
            .flush (flush),
            .din   (in_data),
            .dout  (out_data[lane_slice(n, WIDTH) +: WIDTH]),
            .valid (out_valid[n])
        );
    end

    assign ptr        = ptr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_cl_demux.sv
// Directed bench for mux_cl_demux: driver pushes expected lane writes,
// a monitor pops them on every accepted word; state checks run inline.
module tb_mux_cl_demux;

    localparam int WIDTH = 1;
    localparam int LANES = 8;
    localparam int SEL_W = 3;
    localparam int E_W   = SEL_W + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data = '0;
    logic [SEL_W-1:0]       in_sel = '0;
    logic                   auto_mode = 1'b0;
    logic                   flush = 1'b0;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic [LANES-1:0]       out_ack = '0;
    logic [SEL_W-1:0]       ptr;
    logic                   frame_done;

    logic [E_W-1:0]   exp_q[$];
    logic [WIDTH-1:0] model_data [LANES];
    int checks = 0;
    int errors = 0;

    mux_cl_demux #(.WIDTH(WIDTH), .LANES(LANES), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .auto_mode  (auto_mode),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .ptr        (ptr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*WIDTH-1:0] model_vec();
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        for (int n = 0; n < LANES; n++) v[n*WIDTH +: WIDTH] = model_data[n];
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one word for one cycle; lane is the lane the word must land in.
    task automatic send(input int lane, input logic [WIDTH-1:0] d,
                        input logic [LANES-1:0] ack, input logic exp_rdy,
                        input string name);
        logic [SEL_W-1:0] l;
        l        = lane[SEL_W-1:0];
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = auto_mode ? (l ^ 3'd5) : l;
        out_ack  = ack;
        #1;
        chk(name, 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            exp_q.push_back({l, d});
            model_data[lane] = d;
        end
        @(negedge clk);
    endtask

    // Monitor: every accepted word must match the next queued expectation.
    initial begin
        logic [E_W-1:0]   e;
        logic [SEL_W-1:0] l;
        logic [WIDTH-1:0] d;
        forever begin
            @(posedge clk);
            if (rst_n && in_valid && in_ready) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_accept: got accept with no expected write, expected none");
                end else begin
                    e = exp_q.pop_front();
                    l = e[E_W-1 -: SEL_W];
                    d = e[WIDTH-1:0];
                    if (out_valid[l] !== 1'b1 || out_data[int'(l)*WIDTH +: WIDTH] !== d) begin
                        errors++;
                        $display("FAIL lane_write: lane %0d got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                                 l, out_valid[l], out_data[int'(l)*WIDTH +: WIDTH], d);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] fill_bits;
        fill_bits = 8'b01001101;
        for (int n = 0; n < LANES; n++) model_data[n] = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        tick();

        // Direct fill
        for (int i = 0; i < LANES; i++) send(i, fill_bits[i], 8'h00, 1'b1, "fill_rdy");
        in_valid = 1'b0;
        #1;
        chk("fill_valid", 32'(out_valid), 32'hFF);
        chk("fill_data", 32'(out_data), 32'h4D);
        send(3, 1'b0, 8'h00, 1'b0, "ninth_rdy");
        in_valid = 1'b0;
        out_ack  = 8'hFF;
        tick();
        out_ack  = 8'h00;
        #1;
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_data_kept", 32'(out_data), 32'(model_vec()));

        // Auto frame with trailing acks
        tick();
        auto_mode = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("to_auto_rdy", 32'(in_ready), 32'h0);
        tick();
        for (int i = 0; i < LANES; i++) begin
            #1;
            chk("auto_ptr", 32'(ptr), 32'(i));
            chk("auto_fd_low", 32'(frame_done), 32'h0);
            send(i, WIDTH'(i % 3 == 0), (i > 0) ? (8'd1 << (i - 1)) : 8'h00, 1'b1, "auto_rdy");
        end
        in_valid = 1'b0;
        out_ack  = 8'h80;
        #1;
        chk("frame_done", 32'(frame_done), 32'h1);
        chk("auto_wrap_ptr", 32'(ptr), 32'h0);
        tick();
        out_ack = 8'h00;
        #1;
        chk("frame_done_pulse", 32'(frame_done), 32'h0);
        chk("auto_acked_valid", 32'(out_valid), 32'h0);

        // Ack/write collision in direct mode
        tick();
        auto_mode = 1'b0;
        tick();
        send(5, 1'b0, 8'h00, 1'b1, "coll_pre");
        send(5, 1'b1, 8'h20, 1'b1, "coll_rdy");
        in_valid = 1'b0;
        out_ack  = 8'h00;
        #1;
        chk("coll_valid", 32'(out_valid), 32'h20);
        chk("coll_data", 32'(out_data), 32'(model_vec()));
        tick();
        out_ack = 8'h01;
        tick();
        out_ack = 8'h00;
        #1;
        chk("ack_empty_ignored", 32'(out_valid), 32'h20);
        tick();
        out_ack = 8'h20;
        tick();
        out_ack = 8'h00;
        #1;
        chk("ack_clears_valid", 32'(out_valid), 32'h0);
        chk("ack_keeps_data", 32'(out_data), 32'(model_vec()));

        // Stall in auto mode
        auto_mode = 1'b1;
        tick();
        for (int i = 0; i < LANES; i++) send(i, WIDTH'(i & 1), 8'h00, 1'b1, "frame2_rdy");
        in_valid = 1'b0;
        out_ack  = 8'h0F;
        tick();
        out_ack = 8'h00;
        for (int i = 0; i < 4; i++) send(i, WIDTH'(~i & 1), 8'h00, 1'b1, "refill_rdy");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ptr", 32'(ptr), 32'h4);
            send(4, 1'b1, 8'h00, 1'b0, "stall_rdy");
        end
        send(4, 1'b1, 8'h10, 1'b1, "stall_release_rdy");
        in_valid = 1'b0;
        out_ack  = 8'h00;
        #1;
        chk("stall_ptr_adv", 32'(ptr), 32'h5);

        // Mode switch then flush
        send(5, 1'b0, 8'h20, 1'b1, "ptr6_rdy");
        auto_mode = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        out_ack   = 8'h41;
        #1;
        chk("pre_switch_ptr", 32'(ptr), 32'h6);
        chk("switch_rdy", 32'(in_ready), 32'h0);
        tick();
        in_valid = 1'b0;
        out_ack  = 8'hC3;
        #1;
        chk("switch_ptr", 32'(ptr), 32'h0);
        tick();
        out_ack = 8'h00;
        #1;
        chk("pre_flush_valid", 32'(out_valid), 32'h3C);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = ~model_data[0];
        #1;
        chk("flush_rdy", 32'(in_ready), 32'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ptr", 32'(ptr), 32'h0);
        chk("flush_data_kept", 32'(out_data), 32'(model_vec()));

        // Async reset mid-frame
        auto_mode = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send(i, 1'b1, 8'h00, 1'b1, "pre_rst_rdy");
        in_valid = 1'b0;
        #1;
        chk("pre_rst_ptr", 32'(ptr), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_ptr", 32'(ptr), 32'h0);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        chk("async_rst_data", 32'(out_data), 32'h0);
        for (int n = 0; n < LANES; n++) model_data[n] = '0;
        tick();
        auto_mode = 1'b0;
        rst_n     = 1'b1;
        tick();
        #1;
        chk("post_rst_rdy", 32'(in_ready), 32'h1);
        chk("post_rst_fd", 32'(frame_done), 32'h0);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
